// File: rtl/qam64_pkg.sv
// Shared 64-QAM definitions: widths, float32 level table, Gray-index to
// level function and the output beat payload. The demapper uses the same table.
package qam64_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYM_W  = 6;
  localparam int unsigned SAMP_W = 32;
  localparam int unsigned GRAY_W = 3;
  localparam int unsigned ACC_W  = 12;
  localparam int unsigned CNT_W  = 4;

  // IEEE-754 single-precision encodings of the eight amplitude levels
  localparam logic [SAMP_W-1:0] LVL_M7 = 32'hC0E0_0000;
  localparam logic [SAMP_W-1:0] LVL_M5 = 32'hC0A0_0000;
  localparam logic [SAMP_W-1:0] LVL_M3 = 32'hC040_0000;
  localparam logic [SAMP_W-1:0] LVL_M1 = 32'hBF80_0000;
  localparam logic [SAMP_W-1:0] LVL_P1 = 32'h3F80_0000;
  localparam logic [SAMP_W-1:0] LVL_P3 = 32'h4040_0000;
  localparam logic [SAMP_W-1:0] LVL_P5 = 32'h40A0_0000;
  localparam logic [SAMP_W-1:0] LVL_P7 = 32'h40E0_0000;

  // One output beat: raw symbol, I/Q levels and packet-end marker
  typedef struct packed {
    logic [SYM_W-1:0]  sym;
    logic [SAMP_W-1:0] i;
    logic [SAMP_W-1:0] q;
    logic              last;
  } beat_t;

  // Gray-coded 3-bit index to float32 level
  function automatic logic [SAMP_W-1:0] gray_level(input logic [GRAY_W-1:0] g);
    logic [SAMP_W-1:0] lvl;
    case (g)
      3'b000:  lvl = LVL_M7;
      3'b001:  lvl = LVL_M5;
      3'b011:  lvl = LVL_M3;
      3'b010:  lvl = LVL_M1;
      3'b110:  lvl = LVL_P1;
      3'b111:  lvl = LVL_P3;
      3'b101:  lvl = LVL_P5;
      default: lvl = LVL_P7;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/qam64_level_lut.sv
// Combinational Gray-index to float32 level lookup.
//   gray    : 3-bit Gray-coded amplitude index
//   level_c : float32 amplitude level
module qam64_level_lut
  import qam64_pkg::*;
(
  input  logic [GRAY_W-1:0] gray,
  output logic [SAMP_W-1:0] level_c
);

  always_comb level_c = gray_level(gray);

endmodule

// File: rtl/qam64_mapper.sv
// Streaming 64-QAM mapper: packs bytes MSB-first into 6-bit symbols and
// maps each to a Gray-coded float32 I/Q pair.
//   clk, rst                 : clock, synchronous active-high reset
//   s_data/s_valid/s_last    : input byte stream, s_ready accepts
//   m_i/m_q/m_sym/m_last     : output beat, m_valid/m_ready handshake
module qam64_mapper
  import qam64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] s_data,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic [SAMP_W-1:0] m_i,
  output logic [SAMP_W-1:0] m_q,
  output logic [SYM_W-1:0]  m_sym,
  output logic              m_last,
  output logic              m_valid,
  input  logic              m_ready
);

  logic [ACC_W-1:0]  acc, acc_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              last_pend, last_pend_n;
  beat_t             out_q, out_n;
  logic              out_valid, out_valid_n;
  logic [SAMP_W-1:0] lvl_i_c, lvl_q_c;
  logic              slot_free_c, accept_c, pad_c, emit_c;

  // Levels for the symbol currently at the top of the accumulator
  qam64_level_lut u_lut_i (
    .gray    (acc[ACC_W-SYM_W +: GRAY_W]),
    .level_c (lvl_i_c)
  );

  qam64_level_lut u_lut_q (
    .gray    (acc[ACC_W-GRAY_W +: GRAY_W]),
    .level_c (lvl_q_c)
  );

  // Handshake decisions; accept needs cnt < 6, emit needs cnt >= 6 or a pad
  always_comb begin
    slot_free_c = !out_valid || m_ready;
    s_ready     = !rst && !last_pend && (cnt < CNT_W'(SYM_W));
    accept_c    = s_valid && s_ready;
    pad_c       = last_pend && ((cnt == CNT_W'(2)) || (cnt == CNT_W'(4)));
    emit_c      = slot_free_c && ((cnt >= CNT_W'(SYM_W)) || pad_c);
  end

  // Next-state: accumulator, bit count, packet-end flag, output register
  always_comb begin
    acc_n       = acc;
    cnt_n       = cnt;
    last_pend_n = last_pend;
    out_n       = out_q;
    out_valid_n = out_valid;

    if (out_valid && m_ready) begin
      out_valid_n = 1'b0;
    end

    if (accept_c) begin
      // Bits below the valid region are kept zero, so OR-ing places the byte
      acc_n       = acc | (ACC_W'(s_data) << (CNT_W'(ACC_W - BYTE_W) - cnt));
      cnt_n       = cnt + CNT_W'(BYTE_W);
      last_pend_n = s_last;
    end else if (emit_c) begin
      out_n.sym = acc[ACC_W-1 -: SYM_W];
      out_n.i   = lvl_i_c;
      out_n.q   = lvl_q_c;
      if (pad_c) begin
        // Residual bits are already zero-padded below the valid region
        acc_n = '0;
        cnt_n = '0;
      end else begin
        acc_n = acc << SYM_W;
        cnt_n = cnt - CNT_W'(SYM_W);
      end
      out_n.last  = last_pend && (cnt_n == '0);
      if (out_n.last) begin
        last_pend_n = 1'b0;
      end
      out_valid_n = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      last_pend <= 1'b0;
      out_q     <= '0;
      out_valid <= 1'b0;
    end else begin
      acc       <= acc_n;
      cnt       <= cnt_n;
      last_pend <= last_pend_n;
      out_q     <= out_n;
      out_valid <= out_valid_n;
    end
  end

  assign m_i     = out_q.i;
  assign m_q     = out_q.q;
  assign m_sym   = out_q.sym;
  assign m_last  = out_q.last;
  assign m_valid = out_valid;

endmodule

// File: tb/tb_qam64_mapper.sv
// Self-checking bench for qam64_mapper: directed vector table, multi-cycle
// corner sequences and randomized streams against a bit-queue model.
module tb_qam64_mapper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_i, m_q;
  logic [5:0]  m_sym;
  logic        m_last, m_valid, m_ready;

  qam64_mapper dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_i(m_i), .m_q(m_q), .m_sym(m_sym), .m_last(m_last),
    .m_valid(m_valid), .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [5:0] sym; logic [31:0] i; logic [31:0] q; logic last; } tbeat_t;
  typedef struct packed { logic [5:0] sym; logic last; } exp_t;
  typedef struct {
    int           nb;
    logic [23:0]  bytes;   // sent MSB-first
    int           ns;
    logic [23:0]  syms;    // expected symbols MSB-first
    logic [127:0] iv;
    logic [127:0] qv;
    logic [3:0]   lasts;
  } vec_t;

  int     errors = 0;
  int     checks = 0;
  int     nbeats = 0;
  int     cyc = 0;
  int     last_cyc = 0;
  bit     rand_ready = 1'b0;
  bit     stall = 1'b0;
  int     gap_pct = 0;
  exp_t   expq[$];
  tbeat_t cap[$];
  bit     bitq[$];
  vec_t   vecs[4];
  tbeat_t held_b;
  bit     held = 1'b0;
  tbeat_t cur;
  exp_t   e;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Gray index -> level via binary index, then float32 built arithmetically
  function automatic logic [31:0] ref_level(input logic [2:0] g);
    int b, lvl, mag, ex;
    logic s;
    b   = int'(g[2]) * 4 + int'(g[2] ^ g[1]) * 2 + int'(g[2] ^ g[1] ^ g[0]);
    lvl = 2 * b - 7;
    s   = (lvl < 0);
    mag = s ? -lvl : lvl;
    ex  = (mag >= 4) ? 2 : (mag >= 2) ? 1 : 0;
    return {s, 8'(127 + ex), 23'((mag << (23 - ex)) & 32'h007F_FFFF)};
  endfunction

  // float32 level -> Gray index (receive-side inverse)
  function automatic logic [2:0] ref_demap(input logic [31:0] f);
    int ex, mag, lvl, b;
    ex  = int'(f[30:23]) - 127;
    mag = (1 << ex) + int'(f[22:0] >> (23 - ex));
    lvl = f[31] ? -mag : mag;
    b   = (lvl + 7) / 2;
    return 3'(b ^ (b >> 1));
  endfunction

  // Reference packer: bits MSB-first, 6 per symbol, zero-pad at packet end
  task automatic model_byte(input logic [7:0] d, input logic l);
    logic [5:0] s;
    for (int k = 7; k >= 0; k--) bitq.push_back(d[k]);
    while (bitq.size() >= 6 || (l && bitq.size() > 0)) begin
      s = '0;
      for (int k = 5; k >= 0; k--) s[k] = (bitq.size() > 0) ? bitq.pop_front() : 1'b0;
      expq.push_back('{s, 1'b0});
    end
    if (l) expq[expq.size()-1].last = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int budget;
    while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
      s_valid = 1'b0;
      @(posedge clk); #1;
    end
    s_data = d; s_last = l; s_valid = 1'b1; budget = 0;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      budget++;
      if (budget > 500) begin
        checks++; errors++;
        $display("FAIL s_ready_timeout: got s_ready=0 for %0d cycles, expected 1", budget);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    model_byte(d, l);
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain();
    int budget = 0;
    while ((expq.size() > 0 || m_valid) && budget < 3000) begin
      @(posedge clk); #1;
      budget++;
    end
    chk("drain_left", 32'(expq.size()), 32'd0);
  endtask

  task automatic run_vec(input vec_t v);
    int n;
    cap.delete();
    for (int k = 0; k < v.nb; k++) send_byte(v.bytes[23-8*k -: 8], k == v.nb - 1);
    drain();
    chk("vec_beats", 32'(cap.size()), 32'(v.ns));
    n = (cap.size() < v.ns) ? cap.size() : v.ns;
    for (int k = 0; k < n; k++) begin
      chk("vec_sym",  32'(cap[k].sym),  32'(v.syms[23-6*k -: 6]));
      chk("vec_i",    cap[k].i,         v.iv[127-32*k -: 32]);
      chk("vec_q",    cap[k].q,         v.qv[127-32*k -: 32]);
      chk("vec_last", 32'(cap[k].last), 32'(v.lasts[3-k]));
    end
  endtask

  // m_ready driver
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = stall ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Output monitor: scoreboard, loopback demap and hold stability
  always @(negedge clk) begin
    cur = {m_sym, m_i, m_q, m_last};
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(m_valid), 32'd1);
        chk("hold_i", m_i, held_b.i);
        chk("hold_q", m_q, held_b.q);
        chk("hold_sym_last", 32'({m_sym, m_last}), 32'({held_b.sym, held_b.last}));
      end
      if (m_valid && m_ready) begin
        held = 1'b0;
        nbeats++;
        cap.push_back(cur);
        if (m_last) last_cyc = cyc;
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat: got sym %h, expected no beat", m_sym);
        end else begin
          e = expq.pop_front();
          chk("sym",  32'(m_sym),  32'(e.sym));
          chk("last", 32'(m_last), 32'(e.last));
          chk("i",    m_i, ref_level(e.sym[2:0]));
          chk("q",    m_q, ref_level(e.sym[5:3]));
          chk("loopback", 32'({ref_demap(m_q), ref_demap(m_i)}), 32'(e.sym));
        end
      end else if (m_valid) begin
        held   = 1'b1;
        held_b = cur;
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ex_bytes [48];
    int c0, sym, bitv;

    vecs[0] = '{3, 24'h000000, 4, 24'h000000, {4{32'hC0E00000}}, {4{32'hC0E00000}}, 4'b0001};
    vecs[1] = '{3, 24'hFC0FC0, 4, {6'o77, 6'o00, 6'o77, 6'o00},
                {32'h40400000, 32'hC0E00000, 32'h40400000, 32'hC0E00000},
                {32'h40400000, 32'hC0E00000, 32'h40400000, 32'hC0E00000}, 4'b0001};
    vecs[2] = '{1, 24'hA50000, 2, {6'b101001, 6'b010000, 12'h000},
                {32'hC0A00000, 32'hC0E00000, 64'h0},
                {32'h40A00000, 32'hBF800000, 64'h0}, 4'b0100};
    vecs[3] = '{3, 24'hFFFFFF, 4, 24'hFFFFFF, {4{32'h40400000}}, {4{32'h40400000}}, 4'b0001};

    s_valid = 1'b0; s_data = '0; s_last = 1'b0; rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_i", m_i, 32'd0);
    chk("rst_m_q", m_q, 32'd0);
    chk("rst_m_sym_last", 32'({m_sym, m_last}), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;

    // Directed table: full group, packing order, padding
    for (int v = 0; v < 3; v++) run_vec(vecs[v]);

    // Full rate: 30 bytes -> 40 beats, last beat 69 edges after first accept
    nbeats = 0;
    for (int k = 0; k < 30; k++) begin
      send_byte(8'($urandom), k == 29);
      if (k == 0) c0 = cyc;
    end
    drain();
    chk("full_rate_beats", 32'(nbeats), 32'd40);
    chk("full_rate_cycles", 32'(last_cyc - c0), 32'd69);

    // Backpressure: one beat held, accumulator fills, s_ready drops
    stall = 1'b1;
    @(posedge clk); #1;
    send_byte(8'h3C, 1'b0);
    send_byte(8'h5A, 1'b0);
    repeat (3) @(negedge clk);
    chk("stall_s_ready", 32'(s_ready), 32'd0);
    chk("stall_m_valid", 32'(m_valid), 32'd1);
    @(posedge clk); #1;
    stall = 1'b0;
    send_byte(8'hC3, 1'b1);
    drain();

    // Exhaustive map: symbols 0..63 in order packed into 48 bytes
    for (int b = 0; b < 48; b++) ex_bytes[b] = '0;
    for (int p = 0; p < 384; p++) begin
      sym  = p / 6;
      bitv = (sym >> (5 - p % 6)) & 1;
      ex_bytes[p/8][7 - p%8] = bitv[0];
    end
    cap.delete();
    rand_ready = 1'b1;
    for (int b = 0; b < 48; b++) send_byte(ex_bytes[b], b == 47);
    drain();
    chk("exh_beats", 32'(cap.size()), 32'd64);
    for (int k = 0; k < 64 && k < cap.size(); k++) chk("exh_sym", 32'(cap[k].sym), 32'(k));

    // Random backpressure on a 300-byte packet
    nbeats = 0;
    gap_pct = 20;
    for (int k = 0; k < 300; k++) send_byte(8'($urandom), k == 299);
    drain();
    chk("bp_beats", 32'(nbeats), 32'd400);

    // Reset mid-packet, then a clean packet
    gap_pct = 0;
    rand_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_m_last", 32'(m_last), 32'd0);
    expq.delete();
    bitq.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    @(posedge clk); #1;
    run_vec(vecs[3]);

    // Random short packets back-to-back with random gaps and backpressure
    rand_ready = 1'b1;
    gap_pct = 30;
    for (int p = 0; p < 20; p++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int k = 0; k < len; k++) send_byte(8'($urandom), k == len - 1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/qam64_mapper.md
# qam64_mapper

Streaming 64-QAM modulator front end: accepts a byte stream over a valid/ready handshake and packs it MSB-first into 6-bit symbols. Each symbol is Gray-mapped to an I/Q pair of IEEE-754 single-precision levels in {±1, ±3, ±5, ±7}. It sits on the transmit side, ahead of the IFFT/pulse-shaping stage, and is the exact inverse of the 64-QAM demapper on the receive side. Packet boundaries are carried by `last`; a trailing partial symbol is zero-padded.

## Interface
- No parameters. Widths are fixed: byte 8, symbol 6, sample 32 (float32).
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `s_data` in 8: input byte.
- `s_valid` in 1: `s_data` and `s_last` are valid.
- `s_last` in 1: this byte is the final byte of the packet.
- `s_ready` out 1: the mapper accepts a byte this cycle.
- `m_i` out 32: in-phase level, float32.
- `m_q` out 32: quadrature level, float32.
- `m_sym` out 6: raw symbol bits, for debug and scoreboard.
- `m_last` out 1: this is the final symbol of the packet.
- `m_valid` out 1: the output beat is valid.
- `m_ready` in 1: the downstream block accepts the beat.

## Operation
- **Bit accumulator:** 12-bit register `acc` plus a bit count `cnt` in {0, 2, 4, 6, 8, 10, 12}. Valid bits are left-aligned; the oldest bit is the MSB.
- **Byte accept:** occurs when `s_valid && s_ready`. The byte is appended below the existing valid bits and `cnt += 8`.
- **`s_ready`:** equals `!rst && !last_pend && cnt < 6`.
- **Symbol emit:** occurs when `cnt >= 6` and the output slot is free (`!m_valid || m_ready`). The top 6 valid bits are loaded into the output register, the accumulator shifts, and `cnt -= 6`.
- **Exclusivity:** accept and emit are mutually exclusive, because accept requires `cnt < 6` and emit requires `cnt >= 6`.
- **`last` handling:**
  - Accepting a byte with `s_last` sets `last_pend`.
  - While `last_pend` is set and `cnt` is 2 or 4, the residual bits are zero-padded at the LSBs and emitted as one symbol, and `cnt` becomes 0.
  - `m_last` is asserted on the symbol that brings `cnt` to 0 while `last_pend` is set. `last_pend` clears on that emit.
  - Packet length in bytes mod 3 determines the symbol count:
    - 0 → 4k symbols
    - 1 → 4k+2 symbols (last symbol carries 4 pad bits)
    - 2 → 4k+3 symbols (last symbol carries 2 pad bits)
- **Mapping:**
  - I uses `sym[2:0]`; Q uses `sym[5:3]`.
  - Gray map, 3 bits → level: 000→−7, 001→−5, 011→−3, 010→−1, 110→+1, 111→+3, 101→+5, 100→+7.
  - Float32 encodings: −7=C0E00000, −5=C0A00000, −3=C0400000, −1=BF800000, +1=3F800000, +3=40400000, +5=40A00000, +7=40E00000 (hex).
- **Output register:** `m_i`, `m_q`, `m_sym` and `m_last` hold stable while `m_valid && !m_ready`. No beat is dropped or duplicated.

## Timing
- **Reset values:** `acc`=0, `cnt`=0, `last_pend`=0, `m_valid`=0, `m_i`=0, `m_q`=0, `m_sym`=0, `m_last`=0. `s_ready` is 0 while `rst` is high and 1 on the first cycle after reset.
- **Latency:** a byte accepted at edge N produces its first symbol on `m_*` after edge N+1.
- **Full-rate throughput:** 4 symbols per 3 bytes over 7 cycles. The cycle sequence is accept, emit, accept, emit, accept, emit, emit.
- **Backpressure:** with `m_ready`=0, at most one beat is held in the output register. `acc` fills to `cnt` ≥ 6 and `s_ready` falls.
- **Packet gap:** after an `m_last` emit, `s_ready` rises in the next cycle. A new packet may start back-to-back.
- **Reset mid-packet:** the partial symbol, `last_pend` and any held output beat are discarded. No `m_last` is produced for the aborted packet.

## Structure
- **`qam64_pkg`:**
  - The 8 float32 level constants.
  - A Gray-index → level function.
  - Width constants `SYM_W`=6 and `SAMP_W`=32.
  - Shared with the demapper, so both ends use the same table.
- **`qam64_level_lut`:** one combinational sub-module (3 bits in → 32 bits out), instantiated twice, once for I and once for Q.
- **Top-level contents:** the accumulator, the `last_pend` logic and the output register.

## Test plan
- **Single full group:** bytes 0x00,0x00,0x00 with `last` on the third, `m_ready`=1 → 4 beats, each I=Q=C0E00000, `m_last` on the 4th only.
- **Packing order:** bytes 0xFC,0x0F,0xC0 → symbols 111111, 000000, 111111, 000000. The first beat is I=Q=40400000.
- **Padding:** single byte 0xA5 with `s_last` → symbols 101001 and 010000.
  - Beat 1: I=C0A00000, Q=40A00000.
  - Beat 2: I=C0E00000, Q=BF800000, `m_last`=1.
- **Backpressure:** random `m_ready` on a 300-byte stream → symbol sequence identical to the `m_ready`=1 run, 400 beats, outputs stable while stalled.
- **Exhaustive map:** 48 bytes covering all 64 symbols → each I/Q pair matches the table; looping back through the demapper returns the original bits.
- **Reset mid-packet:** assert `rst` after 2 of 3 bytes → `m_valid`=0 the next cycle. A following packet 0xFF,0xFF,0xFF gives 4 beats of I=Q=40400000.
